// File: rtl/lcd_write_arbiter_pkg.sv
// ============================================================================
// lcd_write_arbiter_pkg : shared arbiter state encoding and requester indices
// Revision 1.0
// ============================================================================
`default_nettype none

package lcd_write_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2,
        ST_TURN = 2'd3
    } arb_state_t;

    localparam logic REQ_GAME = 1'b0;
    localparam logic REQ_OVL  = 1'b1;

    function automatic logic [1:0] grant_of(input arb_state_t s);
        case (s)
            ST_OWN0: grant_of = 2'b01;
            ST_OWN1: grant_of = 2'b10;
            default: grant_of = 2'b00;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_out_stage.sv
// ============================================================================
// lcd_out_stage : single-entry valid/ready output register with drain flag
// Revision 1.0
// ============================================================================
`default_nettype none

module lcd_out_stage (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] push_data,
    output logic       in_ready,
    input  logic       out_en,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       drained
);

    logic       valid_q, valid_d;
    logic [7:0] data_q,  data_d;

    // A new byte may enter while the held one leaves in the same cycle.
    assign in_ready  = !valid_q | out_en;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign drained   = !valid_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (push) begin
            valid_d = 1'b1;
            data_d  = push_data;
        end else if (out_en) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/lcd_write_arbiter.sv
// ============================================================================
// lcd_write_arbiter : two-requester round-robin byte arbiter for the LCD port
// Revision 1.0
// ============================================================================
`default_nettype none

module lcd_write_arbiter
    import lcd_write_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 64,
    parameter int WDOG      = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ready,
    input  logic       lcd_en,
    output logic [7:0] lcd_data,
    output logic       lcd_valid,
    output logic [1:0] grant,
    output logic       wdog_err
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int WW = $clog2(WDOG + 1);

    arb_state_t    state_q, state_d;
    logic          rr_q, rr_d;
    logic [BW-1:0] burst_q, burst_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic          wdog_err_q, wdog_err_d;

    logic       own0, own1, owner_valid, wdog_fire;
    logic       acc0, acc1, push, push_last;
    logic [7:0] push_data;
    logic       stg_ready, stg_drained;

    lcd_out_stage u_out_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .in_ready  (stg_ready),
        .out_en    (lcd_en),
        .out_valid (lcd_valid),
        .out_data  (lcd_data),
        .drained   (stg_drained)
    );

    assign grant    = grant_of(state_q);
    assign wdog_err = wdog_err_q;

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        burst_d    = burst_q;
        wdog_d     = wdog_q;
        wdog_err_d = wdog_err_q;

        own0        = (state_q == ST_OWN0);
        own1        = (state_q == ST_OWN1);
        owner_valid = (own0 & req0_valid) | (own1 & req1_valid);
        // Revoke on the WDOG-th consecutive idle cycle of the owner.
        wdog_fire   = (own0 | own1) & !owner_valid & (wdog_q == WW'(WDOG - 1));

        req0_ready = own0 & stg_ready & !wdog_fire;
        req1_ready = own1 & stg_ready & !wdog_fire;
        acc0       = req0_valid & req0_ready;
        acc1       = req1_valid & req1_ready;
        push       = acc0 | acc1;
        push_data  = acc1 ? req1_data : req0_data;
        push_last  = acc1 ? req1_last : req0_last;

        case (state_q)
            ST_IDLE: begin
                if (req0_valid && (!req1_valid || rr_q == REQ_GAME)) begin
                    state_d = ST_OWN0;
                    burst_d = '0;
                    wdog_d  = '0;
                end else if (req1_valid) begin
                    state_d = ST_OWN1;
                    burst_d = '0;
                    wdog_d  = '0;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (push) begin
                    burst_d = burst_q + BW'(1);
                    wdog_d  = '0;
                    if (push_last || burst_q == BW'(MAX_BURST - 1)) begin
                        state_d = ST_TURN;
                        rr_d    = own0 ? REQ_OVL : REQ_GAME;
                    end
                end else if (wdog_fire) begin
                    state_d    = ST_TURN;
                    rr_d       = own0 ? REQ_OVL : REQ_GAME;
                    wdog_err_d = 1'b1;
                end else if (!owner_valid) begin
                    wdog_d = wdog_q + WW'(1);
                end
            end
            ST_TURN: begin
                if (stg_drained) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rr_q       <= REQ_GAME;
            burst_q    <= '0;
            wdog_q     <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            burst_q    <= burst_d;
            wdog_q     <= wdog_d;
            wdog_err_q <= wdog_err_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lcd_write_arbiter.sv
// ============================================================================
// tb_lcd_write_arbiter : table vectors plus scoreboard sequences for the arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_lcd_write_arbiter;

    localparam int C_MAXB = 64;
    localparam int C_WD   = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       req0_valid = 1'b0, req0_last = 1'b0, req0_ready;
    logic [7:0] req0_data = 8'h00;
    logic       req1_valid = 1'b0, req1_last = 1'b0, req1_ready;
    logic [7:0] req1_data = 8'h00;
    logic       lcd_en = 1'b0, lcd_valid, wdog_err;
    logic [7:0] lcd_data;
    logic [1:0] grant;

    always #5 clk = ~clk;

    lcd_write_arbiter #(.MAX_BURST(C_MAXB), .WDOG(C_WD)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
        .lcd_en(lcd_en), .lcd_data(lcd_data), .lcd_valid(lcd_valid),
        .grant(grant), .wdog_err(wdog_err)
    );

    typedef struct packed { logic [7:0] d; logic l; } src_t;
    typedef struct packed {
        logic v0; logic [7:0] d0; logic l0; logic en;
        logic [1:0] g; logic rdy; logic lv; logic [7:0] ld;
    } vec_t;

    src_t       src0[$], src1[$];
    logic [7:0] sb[$];
    logic [1:0] gseq[$];
    int         bseq[$];
    int         n_checks = 0, n_fail = 0;
    bit         auto_drv = 1'b0, prev_acc = 1'b0;
    logic [7:0] prev_byte = 8'h00;
    logic [1:0] prev_grant = 2'b00;
    int         cur_burst = 0, own0_cycles = 0;
    vec_t       tbl[7];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic present();
        if (auto_drv) begin
            req0_valid = (src0.size() > 0);
            req0_data  = (src0.size() > 0) ? src0[0].d : 8'h00;
            req0_last  = (src0.size() > 0) ? src0[0].l : 1'b0;
            req1_valid = (src1.size() > 0);
            req1_data  = (src1.size() > 0) ? src1[0].d : 8'h00;
            req1_last  = (src1.size() > 0) ? src1[0].l : 1'b0;
        end
    endtask

    // Samples mid-cycle: handshakes, scoreboard, grant history.
    task automatic sample();
        bit a0, a1;
        #1;
        if (prev_acc) begin
            check("latency_valid", lcd_valid, 1);
            check("latency_data", lcd_data, prev_byte);
        end
        check("ready_exclusive", req0_ready & req1_ready, 0);
        if (grant != prev_grant) begin
            gseq.push_back(grant);
            if (prev_grant != 2'b00 && grant == 2'b00) begin
                bseq.push_back(cur_burst);
                cur_burst = 0;
            end
        end
        prev_grant = grant;
        if (grant == 2'b01) own0_cycles++;
        a0 = req0_valid && req0_ready;
        a1 = req1_valid && req1_ready;
        prev_acc = a0 | a1;
        if (a0) begin
            sb.push_back(req0_data); prev_byte = req0_data; cur_burst++;
            if (auto_drv) src0.delete(0);
        end
        if (a1) begin
            sb.push_back(req1_data); prev_byte = req1_data; cur_burst++;
            if (auto_drv) src1.delete(0);
        end
        if (lcd_valid && lcd_en) begin
            if (sb.size() == 0) check("sb_unexpected_byte", lcd_data, 32'hFFFF_FFFF);
            else check("sb_data", lcd_data, sb.pop_front());
        end
    endtask

    task automatic tick();
        present();
        sample();
        @(negedge clk);
    endtask

    task automatic run(input int budget, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (src0.size() == 0 && src1.size() == 0 && sb.size() == 0 && grant == 2'b00 && !lcd_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_completed"}, ok, 1);
        repeat (2) tick();
    endtask

    task automatic clear_logs();
        gseq.delete(); bseq.delete(); cur_burst = 0; own0_cycles = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; req0_last = 1'b0; req1_last = 1'b0;
        req0_data = 8'h00; req1_data = 8'h00;
        #1;
        check("rst_grant", grant, 2'b00);
        check("rst_lcd_valid", lcd_valid, 0);
        check("rst_lcd_data", lcd_data, 8'h00);
        check("rst_ready", {req0_ready, req1_ready}, 2'b00);
        check("rst_wdog_err", wdog_err, 0);
        src0.delete(); src1.delete(); sb.delete(); clear_logs();
        prev_acc = 1'b0; prev_grant = 2'b00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] exp_g2[8];
        logic [1:0] exp_g4[4];

        // v0 d0 l0 en | grant rdy0 lcd_valid lcd_data
        tbl[0] = '{1'b1, 8'hA1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00};
        tbl[1] = '{1'b1, 8'hA1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 8'h00};
        tbl[2] = '{1'b1, 8'hA2, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 8'hA1};
        tbl[3] = '{1'b1, 8'hA3, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 8'hA2};
        tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 8'hA3};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00};
        exp_g2 = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        exp_g4 = '{2'b10, 2'b00, 2'b10, 2'b00};

        #2;
        @(negedge clk);
        do_reset();

        // Single requester, three-byte frame
        auto_drv = 1'b0;
        for (int i = 0; i < 7; i++) begin
            req0_valid = tbl[i].v0; req0_data = tbl[i].d0; req0_last = tbl[i].l0; lcd_en = tbl[i].en;
            sample();
            check($sformatf("vec%0d_grant", i), grant, tbl[i].g);
            check($sformatf("vec%0d_ready0", i), req0_ready, tbl[i].rdy);
            check($sformatf("vec%0d_lcd_valid", i), lcd_valid, tbl[i].lv);
            if (tbl[i].lv) check($sformatf("vec%0d_lcd_data", i), lcd_data, tbl[i].ld);
            @(negedge clk);
        end
        req0_valid = 1'b0;

        // Contention from reset: round-robin alternation
        do_reset();
        auto_drv = 1'b1; lcd_en = 1'b1;
        src0.push_back('{8'hB0, 1'b0}); src0.push_back('{8'hB1, 1'b0});
        src0.push_back('{8'hB2, 1'b1}); src0.push_back('{8'hB3, 1'b1});
        src1.push_back('{8'hC0, 1'b0}); src1.push_back('{8'hC1, 1'b1});
        src1.push_back('{8'hC2, 1'b1});
        run(200, "contention");
        check("contention_gseq_len", gseq.size(), 8);
        for (int i = 0; i < 8 && i < gseq.size(); i++)
            check($sformatf("contention_grant%0d", i), gseq[i], exp_g2[i]);

        // Forced rotation after MAX_BURST with the other side idle
        clear_logs();
        for (int i = 0; i < 70; i++) src1.push_back('{8'(i), (i == 69)});
        run(400, "burst");
        check("burst_gseq_len", gseq.size(), 4);
        for (int i = 0; i < 4 && i < gseq.size(); i++)
            check($sformatf("burst_grant%0d", i), gseq[i], exp_g4[i]);
        check("burst_len_first", (bseq.size() > 0) ? bseq[0] : -1, C_MAXB);
        check("burst_len_second", (bseq.size() > 1) ? bseq[1] : -1, 70 - C_MAXB);

        // Output stall holds the byte and blocks the requester
        clear_logs();
        lcd_en = 1'b0;
        src0.push_back('{8'h5A, 1'b0}); src0.push_back('{8'h5B, 1'b1});
        for (int i = 0; i < 6; i++) begin
            tick();
            if (lcd_valid) break;
        end
        for (int k = 0; k < 5; k++) begin
            present();
            sample();
            check("stall_valid", lcd_valid, 1);
            check("stall_data", lcd_data, 8'h5A);
            check("stall_ready", req0_ready, 0);
            @(negedge clk);
        end
        lcd_en = 1'b1;
        run(50, "stall");

        // Watchdog revoke after WDOG idle cycles
        do_reset();
        lcd_en = 1'b1;
        src0.push_back('{8'hD0, 1'b0});
        src1.push_back('{8'hE0, 1'b1});
        run(100, "wdog");
        check("wdog_gseq_len", gseq.size(), 4);
        check("wdog_first_grant", (gseq.size() > 0) ? gseq[0] : 2'b11, 2'b01);
        check("wdog_second_grant", (gseq.size() > 2) ? gseq[2] : 2'b11, 2'b10);
        check("wdog_own_cycles", own0_cycles, 1 + C_WD);
        check("wdog_err_set", wdog_err, 1);

        // Reset mid-burst with rr pointing at req1
        src0.push_back('{8'hF0, 1'b1});
        run(50, "pre_reset");
        for (int i = 0; i < 10; i++) src0.push_back('{8'(8'h60 + i), (i == 9)});
        repeat (4) tick();
        check("midburst_valid", lcd_valid, 1);
        do_reset();
        #1;
        check("post_rst_first_cycle_valid", lcd_valid, 0);
        src0.push_back('{8'h70, 1'b1});
        src1.push_back('{8'h71, 1'b1});
        run(100, "restart");
        check("restart_first_grant", (gseq.size() > 0) ? gseq[0] : 2'b11, 2'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lcd_write_arbiter.md
LCD_WRITE_ARBITER -- requirements
Module: lcd_write_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 64, max bytes per grant before forced rotation.
REQ-002 Parameter WDOG, default 1024, idle-cycle limit while granted before grant is revoked.
REQ-003 Port clk  in  1  system clock (clk_div domain, 100 kHz).
REQ-004 Port rst_n  in  1  reset: one clock; reset is asynchronous and active-low.
REQ-005 Ports req0_valid/req1_valid  in  1  requester byte available (0 = game-board stream, 1 = score/overlay stream).
REQ-006 Ports req0_data/req1_data  in  8  requester byte.
REQ-007 Ports req0_last/req1_last  in  1  byte is final of requester's frame.
REQ-008 Ports req0_ready/req1_ready  out  1  byte accepted this cycle when valid&ready.
REQ-009 Port lcd_en  in  1  LCD controller ready for a byte (en_tran).
REQ-010 Port lcd_data  out  8  byte to LCD controller.
REQ-011 Port lcd_valid  out  1  lcd_data valid; transfer when lcd_valid&lcd_en.
REQ-012 Port grant  out  2  one-hot current owner; 00 when none.
REQ-013 Port wdog_err  out  1  sticky, set on watchdog revoke, cleared by reset only.

Function
REQ-014 FSM states IDLE, OWN0, OWN1, TURN; grant=01 in OWN0, 10 in OWN1, 00 otherwise.
REQ-015 IDLE: if exactly one reqN_valid, go to OWNN next cycle; if both, go to owner indicated by round-robin pointer rr.
REQ-016 rr SHALL point to the requester not most recently granted; rr=0 after reset.
REQ-017 Output stage is a single register: reqN_ready = (state==OWNN) & (!lcd_valid | lcd_en) & !release_pending.
REQ-018 Accepted byte appears on lcd_data with lcd_valid=1 exactly one cycle after acceptance.
REQ-019 lcd_valid and lcd_data SHALL hold stable until lcd_valid&lcd_en; then lcd_valid drops unless a new byte is accepted in the same cycle (back-to-back, one byte/cycle).
REQ-020 Burst counter (width clog2(MAX_BURST+1)) increments per accepted byte, cleared on entering OWN0/OWN1.
REQ-021 Release occurs on accepting a byte with reqN_last=1, or on accepting the MAX_BURST-th byte; no further bytes accepted after release.
REQ-022 After release, FSM enters TURN and stays until the output register has drained (lcd_valid=0), then returns to IDLE; rr updated on release.
REQ-023 Minimum one TURN cycle between any two grants; no byte from the new owner may be output before the old owner's last byte transfers.
REQ-024 Watchdog counter counts cycles in OWNN with reqN_valid=0; cleared on any acceptance; at WDOG it forces release (as REQ-022) and sets wdog_err.
REQ-025 Forced rotation (MAX_BURST) with other requester idle: owner may be regranted after TURN.
REQ-026 Requester valid deassertion while not granted SHALL NOT affect state; arbiter never drops or duplicates an accepted byte.
REQ-027 Simultaneous last-byte acceptance and lcd_en on previous byte: both take effect in the same cycle.

Reset
REQ-028 On rst_n=0 (async): state=IDLE, rr=0, grant=00, lcd_valid=0, lcd_data=8'h00, req0_ready=req1_ready=0, burst and watchdog counters=0, wdog_err=0.
REQ-029 Reset mid-burst discards the byte in the output register; no lcd_valid in the first cycle after rst_n rises.

Structure
REQ-030 State encoding and requester index constants (REQ_GAME=0, REQ_OVL=1) SHALL live in a shared package used also by requester blocks.
REQ-031 One sub-module lcd_out_stage (single-entry valid/ready register with drain flag) SHALL be instantiated; FSM, counters and rr in the top.
REQ-032 Implementation 120-400 lines RTL; no latches; all state in clk domain.

Verification
REQ-033 Only req0 sends 3 bytes A1,A2,A3(last), lcd_en=1 -> grant=01, lcd_data A1,A2,A3 on consecutive cycles, TURN, IDLE, grant=00.
REQ-034 Both valid from reset -> req0 served first; after its last byte drains, TURN, then req1 granted; next contention grants req0.
REQ-035 req1 sends 70 bytes, MAX_BURST=64, req0 idle -> release after 64th byte, TURN, regrant req1, remaining 6 bytes delivered in order.
REQ-036 lcd_en held 0 for 5 cycles with byte 5A pending -> lcd_data=5A, lcd_valid=1 stable for 5 cycles, req_ready=0, no byte loss.
REQ-037 req0 granted, sends 1 byte then valid=0, WDOG=16 -> release after 16 idle cycles, wdog_err=1, req1 then granted.
REQ-038 rst_n pulsed low mid-burst -> all outputs at REQ-028 values immediately, arbitration restarts with rr=0.
